sync_result_fifo: RTL and testbench

- Downstream stage that sits directly after a compiled sync-handshake compute block, for example the fib test block.
- Accepts each result word on that block's out_valid/out_ready/out0 side and buffers it in a small FIFO.
- Re-presents the words to the consumer with the same valid/ready protocol.
- Decouples compute from consumer backpressure so results are never lost or reordered.

---
 rtl/sync_result_fifo.sv | 86 ++++++++
 tb/tb_sync_result_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sync_result_fifo.sv
// sync_result_fifo
//   Small result buffer placed after a valid/ready compute block. Each word
//   handshaken on the input side is stored and later re-presented on the
//   output side with the same valid/ready protocol, in strict arrival order.
//   Full and empty are resolved from the stored-word count, not from pointer
//   comparison.
//
// Ports
//   clk        system clock, rising edge
//   nrst       asynchronous active-low reset; discards all stored words
//   in_valid   producer offers in0 this cycle
//   in_ready   FIFO can accept a word (count != DEPTH)
//   in0        producer data, N bits
//   out_valid  FIFO holds at least one word
//   out_ready  consumer takes out0 this cycle
//   out0       head-of-queue word, zero when empty
//   count      number of stored words, 0..DEPTH

module sync_result_fifo #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in0,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out0,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_q;
    logic          push;
    logic          pop;

    // Handshake flags come only from registered count, so neither ready nor
    // valid has a combinational path from the opposite side. When full a
    // push is refused even if a pop happens in the same cycle.
    assign in_ready  = (cnt_q != FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt_q;

    // Zero the output when empty so stale memory never appears on out0.
    assign out0 = out_valid ? mem[rd_ptr] : '0;

    // Storage has no reset; its contents are irrelevant while count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in0;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_result_fifo.sv
module tb_sync_result_fifo;

    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          nrst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in0;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out0;
    logic [AW:0]   count;

    int n_vec;
    int n_miss;

    sync_result_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle: inputs driven for the cycle and the outputs
    // expected during that cycle (i.e. state left by the previous edges).
    typedef struct {
        logic          nrst;
        logic          in_valid;
        logic [N-1:0]  in0;
        logic          out_ready;
        logic          exp_in_ready;
        logic          exp_out_valid;
        logic [N-1:0]  exp_out0;
        logic [AW:0]   exp_count;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_ir, input logic e_ov,
                             input logic [N-1:0] e_o0, input logic [AW:0] e_cnt);
        check({tag, " in_ready"},  32'(in_ready),  32'(e_ir));
        check({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, " out0"},      32'(out0),      32'(e_o0));
        check({tag, " count"},     32'(count),     32'(e_cnt));
    endtask

    task automatic drive(input logic v, input logic [N-1:0] d, input logic r);
        in_valid  = v;
        in0       = d;
        out_ready = r;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        nrst      = 1'b0;
        in_valid  = 1'b0;
        in0       = '0;
        out_ready = 1'b0;

        //               nrst  iv   in0     or    ir    ov    out0    cnt
        // reset then idle
        vq.push_back('{1'b0, 1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 16'd0,     3'd0});
        vq.push_back('{1'b0, 1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 16'd0,     3'd0});
        vq.push_back('{1'b1, 1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 16'd0,     3'd0});
        // single fib(21) result, consumer always ready
        vq.push_back('{1'b1, 1'b1, 16'd10946, 1'b1, 1'b1, 1'b0, 16'd0,     3'd0});
        vq.push_back('{1'b1, 1'b0, 16'd0,     1'b1, 1'b1, 1'b1, 16'd10946, 3'd1});
        vq.push_back('{1'b1, 1'b0, 16'd0,     1'b1, 1'b1, 1'b0, 16'd0,     3'd0});
        // fill under backpressure; word 5 held by producer
        vq.push_back('{1'b1, 1'b1, 16'd1,     1'b0, 1'b1, 1'b0, 16'd0,     3'd0});
        vq.push_back('{1'b1, 1'b1, 16'd2,     1'b0, 1'b1, 1'b1, 16'd1,     3'd1});
        vq.push_back('{1'b1, 1'b1, 16'd3,     1'b0, 1'b1, 1'b1, 16'd1,     3'd2});
        vq.push_back('{1'b1, 1'b1, 16'd4,     1'b0, 1'b1, 1'b1, 16'd1,     3'd3});
        vq.push_back('{1'b1, 1'b1, 16'd5,     1'b0, 1'b0, 1'b1, 16'd1,     3'd4});
        vq.push_back('{1'b1, 1'b1, 16'd5,     1'b0, 1'b0, 1'b1, 16'd1,     3'd4});
        // full with both sides active: pop only
        vq.push_back('{1'b1, 1'b1, 16'd5,     1'b1, 1'b0, 1'b1, 16'd1,     3'd4});
        // now push 5 and pop 2 together
        vq.push_back('{1'b1, 1'b1, 16'd5,     1'b1, 1'b1, 1'b1, 16'd2,     3'd3});
        vq.push_back('{1'b1, 1'b0, 16'd0,     1'b1, 1'b1, 1'b1, 16'd3,     3'd3});
        vq.push_back('{1'b1, 1'b0, 16'd0,     1'b1, 1'b1, 1'b1, 16'd4,     3'd2});
        vq.push_back('{1'b1, 1'b0, 16'd0,     1'b1, 1'b1, 1'b1, 16'd5,     3'd1});
        vq.push_back('{1'b1, 1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 16'd0,     3'd0});

        foreach (vq[i]) begin
            @(negedge clk);
            nrst = vq[i].nrst;
            drive(vq[i].in_valid, vq[i].in0, vq[i].out_ready);
            #1;
            check_all($sformatf("vec%0d", i), vq[i].exp_in_ready, vq[i].exp_out_valid,
                      vq[i].exp_out0, vq[i].exp_count);
        end

        // wrap-around streaming: 100..109 with both sides active
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, N'(100 + i), 1'b1);
            #1;
            if (i == 0) check_all("stream0", 1'b1, 1'b0, 16'd0, 3'd0);
            else        check_all($sformatf("stream%0d", i), 1'b1, 1'b1, N'(100 + i - 1), 3'd1);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b1);
        #1;
        check_all("stream_last", 1'b1, 1'b1, 16'd109, 3'd1);
        @(negedge clk);
        drive(1'b0, '0, 1'b0);
        #1;
        check_all("stream_drained", 1'b1, 1'b0, 16'd0, 3'd0);

        // reset mid-operation with three words stored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, N'(11 + i), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0);
        #1;
        check_all("pre_reset", 1'b1, 1'b1, 16'd11, 3'd3);
        #2;
        nrst = 1'b0;
        #1;
        check_all("async_reset", 1'b1, 1'b0, 16'd0, 3'd0);
        @(negedge clk);
        nrst = 1'b1;
        drive(1'b1, 16'd7, 1'b0);
        #1;
        check_all("post_reset_idle", 1'b1, 1'b0, 16'd0, 3'd0);
        @(negedge clk);
        drive(1'b0, '0, 1'b1);
        #1;
        check_all("post_reset_word", 1'b1, 1'b1, 16'd7, 3'd1);
        @(negedge clk);
        drive(1'b0, '0, 1'b1);
        #1;
        check_all("post_reset_empty", 1'b1, 1'b0, 16'd0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
